lspc_irq_ctrl: RTL and testbench

//  Interrupt controller downstream of lspc_timer. Merges the timer IRQ (lspc_timer D46A_OUT), the

---
 rtl/lspc_irq_ctrl.sv | 118 +++++++++++
 tb/tb_lspc_irq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lspc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// lspc_irq_ctrl
//
// Interrupt controller that sits downstream of lspc_timer. It merges three
// interrupt sources into pending flags:
//   - the timer IRQ level from lspc_timer,
//   - the vertical-blank IRQ level from the raster logic,
//   - a one-shot cold-boot IRQ raised on reset release.
// It drives the 68K active-low interrupt priority level with a fixed priority
// of boot (level 3) > timer (level 2) > VBL (level 1).
//
// Parameters
//   SYNC_STAGES  synchroniser depth for TIMER_IRQ and VBL_IRQ (2..3)
//   BOOT_IRQ_EN  1 = boot flag is raised on reset release, 0 = never raised
//
// Ports
//   CLK_24M      in   1  system clock, all state on its rising edge
//   RESET        in   1  asynchronous, active-high reset
//   TIMER_IRQ    in   1  timer IRQ level, asynchronous to CLK_24M
//   VBL_IRQ      in   1  vertical-blank IRQ level, asynchronous to CLK_24M
//   WR_IRQ_ACK   in   1  one-cycle write strobe for the acknowledge register
//   M68K_DATA    in   3  ack mask: bit0 boot, bit1 timer, bit2 VBL
//   nIPL         out  3  68K interrupt priority level, active low
//   IRQ_PENDING  out  3  pending flags {vbl, timer, boot}
//   IRQ_MISSED   out  3  sticky overrun flags, same bit order as IRQ_PENDING
// -----------------------------------------------------------------------------
module lspc_irq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter bit BOOT_IRQ_EN = 1'b1
) (
    input  logic       CLK_24M,
    input  logic       RESET,
    input  logic       TIMER_IRQ,
    input  logic       VBL_IRQ,
    input  logic       WR_IRQ_ACK,
    input  logic [2:0] M68K_DATA,
    output logic [2:0] nIPL,
    output logic [2:0] IRQ_PENDING,
    output logic [2:0] IRQ_MISSED
);

    logic [SYNC_STAGES-1:0] timerSync_q;
    logic [SYNC_STAGES-1:0] vblSync_q;
    logic                   timerPrev_q;
    logic                   vblPrev_q;
    logic                   bootDone_q;
    logic [2:0]             pend_q;
    logic [2:0]             pend_d;
    logic [2:0]             missed_q;
    logic [2:0]             missed_d;
    logic [2:0]             nIpl_q;
    logic [2:0]             nIpl_d;
    logic [2:0]             setPulse;
    logic [2:0]             ackMask;
    logic [2:0]             level;

    // Synchronisers for the two asynchronous levels, plus a one-flop history
    // of the synchronised value used by the rising-edge detectors. bootDone_q
    // marks that the first edge after reset release has already passed, so
    // the boot flag is raised exactly once per reset.
    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            timerSync_q <= '0;
            vblSync_q   <= '0;
            timerPrev_q <= 1'b0;
            vblPrev_q   <= 1'b0;
            bootDone_q  <= 1'b0;
        end else begin
            timerSync_q <= {timerSync_q[SYNC_STAGES-2:0], TIMER_IRQ};
            vblSync_q   <= {vblSync_q[SYNC_STAGES-2:0], VBL_IRQ};
            timerPrev_q <= timerSync_q[SYNC_STAGES-1];
            vblPrev_q   <= vblSync_q[SYNC_STAGES-1];
            bootDone_q  <= 1'b1;
        end
    end

    // Flag update. A set pulse always wins over an ack of the same bit so a
    // new event is never lost; the overrun flag is only raised when a set
    // lands on a bit that is already pending and is not being acked, and any
    // ack of a bit clears its overrun flag. The priority encode looks at the
    // current pending flags, so nIPL follows pend one edge later.
    always_comb begin
        ackMask  = WR_IRQ_ACK ? M68K_DATA : 3'b000;
        setPulse = {vblSync_q[SYNC_STAGES-1] & ~vblPrev_q,
                    timerSync_q[SYNC_STAGES-1] & ~timerPrev_q,
                    ~bootDone_q & BOOT_IRQ_EN};
        pend_d   = setPulse | (pend_q & ~ackMask);
        missed_d = (missed_q | (setPulse & pend_q)) & ~ackMask;
        level    = 3'd0;
        if (pend_q[0]) begin
            level = 3'd3;
        end else if (pend_q[1]) begin
            level = 3'd2;
        end else if (pend_q[2]) begin
            level = 3'd1;
        end
        nIpl_d = ~level;
    end

    // All outputs come straight from flops so nIPL can never glitch through
    // an intermediate code while the pending flags change.
    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            pend_q   <= 3'b000;
            missed_q <= 3'b000;
            nIpl_q   <= 3'b111;
        end else begin
            pend_q   <= pend_d;
            missed_q <= missed_d;
            nIpl_q   <= nIpl_d;
        end
    end

    assign nIPL        = nIpl_q;
    assign IRQ_PENDING = pend_q;
    assign IRQ_MISSED  = missed_q;

endmodule

// File: tb/tb_lspc_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lspc_irq_ctrl
//
// Bench for lspc_irq_ctrl. Two instances share all inputs: instance A with the
// boot IRQ enabled and instance B with it disabled. Directed scenarios check
// against fixed expected values; a randomized phase checks every cycle against
// a behavioural model built from input-sample histories and per-bit rules.
// -----------------------------------------------------------------------------
module tb_lspc_irq_ctrl;

    localparam int SYNC = 2;

    logic       CLK_24M;
    logic       RESET;
    logic       TIMER_IRQ;
    logic       VBL_IRQ;
    logic       WR_IRQ_ACK;
    logic [2:0] M68K_DATA;
    logic [2:0] nIplA, pendA, missA;
    logic [2:0] nIplB, pendB, missB;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state; index 0 models instance A, index 1 instance B.
    logic [2:0] mPend [2];
    logic [2:0] mMiss [2];
    logic [2:0] mNipl [2];
    bit         mArmed;
    bit         tHist [$];
    bit         vHist [$];

    lspc_irq_ctrl #(.SYNC_STAGES(SYNC), .BOOT_IRQ_EN(1'b1)) dutA (
        .CLK_24M(CLK_24M), .RESET(RESET), .TIMER_IRQ(TIMER_IRQ), .VBL_IRQ(VBL_IRQ),
        .WR_IRQ_ACK(WR_IRQ_ACK), .M68K_DATA(M68K_DATA),
        .nIPL(nIplA), .IRQ_PENDING(pendA), .IRQ_MISSED(missA)
    );

    lspc_irq_ctrl #(.SYNC_STAGES(SYNC), .BOOT_IRQ_EN(1'b0)) dutB (
        .CLK_24M(CLK_24M), .RESET(RESET), .TIMER_IRQ(TIMER_IRQ), .VBL_IRQ(VBL_IRQ),
        .WR_IRQ_ACK(WR_IRQ_ACK), .M68K_DATA(M68K_DATA),
        .nIPL(nIplB), .IRQ_PENDING(pendB), .IRQ_MISSED(missB)
    );

    initial CLK_24M = 1'b0;
    always #5 CLK_24M = ~CLK_24M;

    // Model reset: no flags, no request, boot armed, and an all-low history
    // of input samples.
    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mPend[i] = 3'b000;
            mMiss[i] = 3'b000;
            mNipl[i] = 3'b111;
        end
        mArmed = 1'b1;
        tHist.delete();
        vHist.delete();
        for (int i = 0; i <= SYNC; i++) begin
            tHist.push_back(1'b0);
            vHist.push_back(1'b0);
        end
    endtask

    // One clock edge of the model. A low-to-high step between two consecutive
    // input samples taken SYNC edges ago becomes a set event on this edge.
    task automatic modelStep();
        bit         tRise, vRise;
        logic [2:0] ackM, setEv, lvl;
        if (RESET) begin
            modelReset();
            return;
        end
        tHist.push_back(TIMER_IRQ);
        vHist.push_back(VBL_IRQ);
        tRise = tHist[1] && !tHist[0];
        vRise = vHist[1] && !vHist[0];
        void'(tHist.pop_front());
        void'(vHist.pop_front());
        ackM = WR_IRQ_ACK ? M68K_DATA : 3'b000;
        for (int i = 0; i < 2; i++) begin
            if (mPend[i][0])      lvl = 3'd3;
            else if (mPend[i][1]) lvl = 3'd2;
            else if (mPend[i][2]) lvl = 3'd1;
            else                  lvl = 3'd0;
            mNipl[i] = ~lvl;
            setEv = {vRise, tRise, (mArmed && i == 0)};
            for (int b = 0; b < 3; b++) begin
                if (ackM[b])                         mMiss[i][b] = 1'b0;
                else if (setEv[b] && mPend[i][b])    mMiss[i][b] = 1'b1;
                if (setEv[b])                        mPend[i][b] = 1'b1;
                else if (ackM[b])                    mPend[i][b] = 1'b0;
            end
        end
        mArmed = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        modelStep();
        @(posedge CLK_24M);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; TIMER_IRQ = 1'b0; VBL_IRQ = 1'b0; WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
        modelReset();
        tick(); tick();
        testsRun++; if (nIplA !== 3'b111) begin testsFailed++; $display("[TB] FAIL reset_nipl: got %b want 111", nIplA); end
        testsRun++; if (pendA !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_pend: got %b want 000", pendA); end
        testsRun++; if (missA !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_miss: got %b want 000", missA); end
        RESET = 1'b0;
        tick();
        testsRun++; if (pendA !== 3'b001) begin testsFailed++; $display("[TB] FAIL boot_pend: got %b want 001", pendA); end
        testsRun++; if (nIplA !== 3'b111) begin testsFailed++; $display("[TB] FAIL boot_nipl_c1: got %b want 111", nIplA); end
        testsRun++; if (pendB !== 3'b000) begin testsFailed++; $display("[TB] FAIL noboot_pend: got %b want 000", pendB); end
        tick();
        testsRun++; if (nIplA !== 3'b100) begin testsFailed++; $display("[TB] FAIL boot_nipl_c2: got %b want 100", nIplA); end
        testsRun++; if (nIplB !== 3'b111) begin testsFailed++; $display("[TB] FAIL noboot_nipl: got %b want 111", nIplB); end
        WR_IRQ_ACK = 1'b1; M68K_DATA = 3'b001;
        tick();
        WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
        testsRun++; if (pendA !== 3'b000) begin testsFailed++; $display("[TB] FAIL boot_ack_pend: got %b want 000", pendA); end
        tick();
        testsRun++; if (nIplA !== 3'b111) begin testsFailed++; $display("[TB] FAIL boot_ack_nipl: got %b want 111", nIplA); end
    endtask

    task automatic test_timer();
        TIMER_IRQ = 1'b1;
        tick(); tick();
        testsRun++; if (pendA !== 3'b000) begin testsFailed++; $display("[TB] FAIL timer_early: got %b want 000", pendA); end
        tick();
        testsRun++; if (pendA !== 3'b010) begin testsFailed++; $display("[TB] FAIL timer_pend: got %b want 010", pendA); end
        testsRun++; if (nIplA !== 3'b111) begin testsFailed++; $display("[TB] FAIL timer_nipl_early: got %b want 111", nIplA); end
        testsRun++; if (pendB !== 3'b010) begin testsFailed++; $display("[TB] FAIL timer_pendB: got %b want 010", pendB); end
        tick();
        testsRun++; if (nIplA !== 3'b101) begin testsFailed++; $display("[TB] FAIL timer_nipl: got %b want 101", nIplA); end
        repeat (4) tick();
        testsRun++; if (pendA !== 3'b010) begin testsFailed++; $display("[TB] FAIL timer_held_pend: got %b want 010", pendA); end
        testsRun++; if (missA !== 3'b000) begin testsFailed++; $display("[TB] FAIL timer_held_miss: got %b want 000", missA); end
        TIMER_IRQ = 1'b0;
        WR_IRQ_ACK = 1'b1; M68K_DATA = 3'b010;
        tick();
        WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
        tick();
        testsRun++; if (nIplA !== 3'b111) begin testsFailed++; $display("[TB] FAIL timer_ack_nipl: got %b want 111", nIplA); end
        testsRun++; if (pendA !== 3'b000) begin testsFailed++; $display("[TB] FAIL timer_ack_pend: got %b want 000", pendA); end
    endtask

    task automatic test_back_to_back();
        TIMER_IRQ = 1'b1; VBL_IRQ = 1'b1;
        repeat (3) tick();
        testsRun++; if (pendA !== 3'b110) begin testsFailed++; $display("[TB] FAIL both_pend: got %b want 110", pendA); end
        tick();
        testsRun++; if (nIplA !== 3'b101) begin testsFailed++; $display("[TB] FAIL both_nipl: got %b want 101", nIplA); end
        TIMER_IRQ = 1'b0; VBL_IRQ = 1'b0;
        WR_IRQ_ACK = 1'b1; M68K_DATA = 3'b010;
        tick();
        WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
        tick();
        testsRun++; if (nIplA !== 3'b110) begin testsFailed++; $display("[TB] FAIL vbl_only_nipl: got %b want 110", nIplA); end
        WR_IRQ_ACK = 1'b1; M68K_DATA = 3'b100;
        tick();
        WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
        tick();
        testsRun++; if (nIplA !== 3'b111) begin testsFailed++; $display("[TB] FAIL both_acked_nipl: got %b want 111", nIplA); end
    endtask

    task automatic test_ack_collision();
        VBL_IRQ = 1'b1;
        tick(); tick();
        WR_IRQ_ACK = 1'b1; M68K_DATA = 3'b100;
        tick();
        WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
        testsRun++; if (pendA !== 3'b100) begin testsFailed++; $display("[TB] FAIL collide_pend: got %b want 100", pendA); end
        testsRun++; if (missA !== 3'b000) begin testsFailed++; $display("[TB] FAIL collide_miss: got %b want 000", missA); end
        VBL_IRQ = 1'b0;
        tick(); tick();
        VBL_IRQ = 1'b1;
        repeat (3) tick();
        testsRun++; if (missA !== 3'b100) begin testsFailed++; $display("[TB] FAIL overrun_miss: got %b want 100", missA); end
        testsRun++; if (pendA !== 3'b100) begin testsFailed++; $display("[TB] FAIL overrun_pend: got %b want 100", pendA); end
        VBL_IRQ = 1'b0;
        WR_IRQ_ACK = 1'b1; M68K_DATA = 3'b100;
        tick();
        WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
        testsRun++; if (missA !== 3'b000) begin testsFailed++; $display("[TB] FAIL overrun_ack_miss: got %b want 000", missA); end
        testsRun++; if (pendA !== 3'b000) begin testsFailed++; $display("[TB] FAIL overrun_ack_pend: got %b want 000", pendA); end
    endtask

    task automatic test_reset_midop();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        testsRun++; if (pendA !== 3'b001) begin testsFailed++; $display("[TB] FAIL rearm_pend: got %b want 001", pendA); end
        TIMER_IRQ = 1'b1; VBL_IRQ = 1'b1;
        repeat (3) tick();
        testsRun++; if (pendA !== 3'b111) begin testsFailed++; $display("[TB] FAIL all_pend: got %b want 111", pendA); end
        #2;
        RESET = 1'b1;
        modelReset();
        TIMER_IRQ = 1'b0; VBL_IRQ = 1'b0;
        #1;
        testsRun++; if (nIplA !== 3'b111) begin testsFailed++; $display("[TB] FAIL async_nipl: got %b want 111", nIplA); end
        testsRun++; if (pendA !== 3'b000) begin testsFailed++; $display("[TB] FAIL async_pend: got %b want 000", pendA); end
        testsRun++; if (missA !== 3'b000) begin testsFailed++; $display("[TB] FAIL async_miss: got %b want 000", missA); end
        RESET = 1'b0;
        tick();
        testsRun++; if (pendA !== 3'b001) begin testsFailed++; $display("[TB] FAIL async_rearm: got %b want 001", pendA); end
        testsRun++; if (pendB !== 3'b000) begin testsFailed++; $display("[TB] FAIL async_rearmB: got %b want 000", pendB); end
    endtask

    task automatic test_no_boot();
        int badCycles;
        badCycles = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (nIplB !== 3'b111 || pendB !== 3'b000) badCycles++;
        end
        testsRun++; if (badCycles != 0) begin testsFailed++; $display("[TB] FAIL noboot_idle: got %0d bad cycles want 0 (last nIPL %b pend %b)", badCycles, nIplB, pendB); end
        WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b111;
        repeat (3) tick();
        M68K_DATA = 3'b000;
        testsRun++; if (pendA !== 3'b001) begin testsFailed++; $display("[TB] FAIL unstrobed_pend: got %b want 001", pendA); end
        testsRun++; if (nIplA !== 3'b100) begin testsFailed++; $display("[TB] FAIL unstrobed_nipl: got %b want 100", nIplA); end
        WR_IRQ_ACK = 1'b1; M68K_DATA = 3'b001;
        tick();
        WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
        tick();
        testsRun++; if (pendA !== 3'b000 || nIplA !== 3'b111) begin testsFailed++; $display("[TB] FAIL final_ack: got pend %b nIPL %b want 000 111", pendA, nIplA); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) TIMER_IRQ = ~TIMER_IRQ;
            if ($urandom_range(0, 3) == 0) VBL_IRQ = ~VBL_IRQ;
            WR_IRQ_ACK = ($urandom_range(0, 5) == 0);
            M68K_DATA  = 3'($urandom_range(0, 7));
            RESET      = ($urandom_range(0, 299) == 0);
            tick();
            testsRun++;
            if ({nIplA, pendA, missA} !== {mNipl[0], mPend[0], mMiss[0]}) begin
                testsFailed++;
                $display("[TB] FAIL random_A cycle %0d: got nIPL %b pend %b miss %b want %b %b %b",
                         c, nIplA, pendA, missA, mNipl[0], mPend[0], mMiss[0]);
            end
            testsRun++;
            if ({nIplB, pendB, missB} !== {mNipl[1], mPend[1], mMiss[1]}) begin
                testsFailed++;
                $display("[TB] FAIL random_B cycle %0d: got nIPL %b pend %b miss %b want %b %b %b",
                         c, nIplB, pendB, missB, mNipl[1], mPend[1], mMiss[1]);
            end
        end
        RESET = 1'b0; WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
    endtask

    initial begin
        RESET = 1'b1;
        TIMER_IRQ = 1'b0; VBL_IRQ = 1'b0; WR_IRQ_ACK = 1'b0; M68K_DATA = 3'b000;
        test_reset();
        test_timer();
        test_back_to_back();
        test_ack_collision();
        test_reset_midop();
        test_no_boot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
